// File: rtl/wb_cmd_master_pkg.sv
// Shared constants for the serial-command wishbone initiator: bus widths used by
// the dispatcher, response status codes and the command FSM state encoding.
package wb_cmd_master_pkg;

  localparam int ADR_W = 7;
  localparam int DAT_W = 32;

  localparam logic [7:0] ST_OK      = 8'hA5;
  localparam logic [7:0] ST_TIMEOUT = 8'hE1;

  // Index of the final write-data byte, and the number of read-data bytes sent back.
  localparam logic [2:0] LAST_WBYTE = 3'd3;
  localparam logic [2:0] WORD_BYTES = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WDATA = 2'd1,
    S_BUS   = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  // Status byte reported for a finished bus cycle.
  function automatic logic [7:0] status_byte(input logic acked);
    return acked ? ST_OK : ST_TIMEOUT;
  endfunction

endpackage

// File: rtl/wb_cmd_master.sv
// Byte-stream command parser driving one single-beat wishbone cycle per command,
// then streaming a status byte (plus read data) back to the serial transmitter.
// One 32-bit shift register assembles write data and serializes read data.
module wb_cmd_master
  import wb_cmd_master_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             rx_ready,
  input  logic             rx_abort,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  input  logic             tx_ready,
  output logic             wb_stb_o,
  output logic             wb_cyc_o,
  output logic             wb_we_o,
  output logic [ADR_W-1:0] wb_adr_o,
  output logic [DAT_W-1:0] wb_dat_o,
  input  logic [DAT_W-1:0] wb_dat_i,
  input  logic             wb_ack_i
);

  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT);

  state_e             state_q, state_d;
  logic               rx_ready_q, rx_ready_d;
  logic               tx_valid_q, tx_valid_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               stb_q, stb_d;
  logic               we_q, we_d;
  logic [ADR_W-1:0]   adr_q, adr_d;
  logic [DAT_W-1:0]   shift_q, shift_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [15:0]        tmo_q, tmo_d;
  logic               drop_rsp_q, drop_rsp_d;

  logic rx_fire, tx_fire, ack_hit, tmo_hit, bus_done, rsp_en;

  // An abort always wins over a byte offered in the same cycle.
  assign rx_fire  = rx_valid && rx_ready_q && !rx_abort;
  assign tx_fire  = tx_valid_q && tx_ready;
  assign ack_hit  = stb_q && wb_ack_i;
  assign tmo_hit  = stb_q && !wb_ack_i && ((tmo_q + 16'd1) == TMO_LIMIT);
  assign bus_done = ack_hit || tmo_hit;
  // Response is suppressed if an abort arrived at any point during the bus cycle.
  assign rsp_en   = !(drop_rsp_q || rx_abort);

  // State and datapath registers; async reset drops stb/cyc immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      rx_ready_q <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      shift_q    <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      drop_rsp_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      rx_ready_q <= rx_ready_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      drop_rsp_q <= drop_rsp_d;
    end
  end

  // Next-state logic for the command FSM.
  always_comb begin
    // NOTE: defaults first so no path through the case infers a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (rx_fire) state_d = rx_data[7] ? S_WDATA : S_BUS;
      end
      S_WDATA: begin
        if (rx_abort)                            state_d = S_IDLE;
        else if (rx_fire && cnt_q == LAST_WBYTE) state_d = S_BUS;
      end
      S_BUS: begin
        if (bus_done) state_d = rsp_en ? S_RESP : S_IDLE;
      end
      S_RESP: begin
        if (rx_abort)                   state_d = S_IDLE;
        else if (tx_fire && cnt_q == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, byte counter and shift register.
  always_comb begin
    rx_ready_d = (state_d == S_IDLE) || (state_d == S_WDATA);
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    stb_d      = stb_q;
    we_d       = we_q;
    adr_d      = adr_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    drop_rsp_d = drop_rsp_q;
    unique case (state_q)
      S_IDLE: begin
        tx_valid_d = 1'b0;
        if (rx_fire) begin
          we_d  = rx_data[7];
          adr_d = rx_data[ADR_W-1:0];
          cnt_d = '0;
          if (!rx_data[7]) begin
            stb_d      = 1'b1;
            tmo_d      = '0;
            drop_rsp_d = 1'b0;
          end
        end
      end
      S_WDATA: begin
        if (rx_abort) begin
          cnt_d = '0;
        end else if (rx_fire) begin
          shift_d = {shift_q[DAT_W-9:0], rx_data};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == LAST_WBYTE) begin
            stb_d      = 1'b1;
            tmo_d      = '0;
            drop_rsp_d = 1'b0;
          end
        end
      end
      S_BUS: begin
        if (rx_abort) drop_rsp_d = 1'b1;
        if (ack_hit) begin
          stb_d = 1'b0;
          if (!we_q) shift_d = wb_dat_i;
        end else if (tmo_hit) begin
          stb_d = 1'b0;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
        if (bus_done) begin
          if (rsp_en) begin
            tx_valid_d = 1'b1;
            tx_data_d  = status_byte(ack_hit);
            cnt_d      = (ack_hit && !we_q) ? WORD_BYTES : 3'd0;
          end else begin
            cnt_d = '0;
          end
        end
      end
      S_RESP: begin
        if (rx_abort) begin
          tx_valid_d = 1'b0;
          cnt_d      = '0;
        end else if (tx_fire) begin
          if (cnt_q == '0) begin
            tx_valid_d = 1'b0;
          end else begin
            tx_data_d = shift_q[DAT_W-1:DAT_W-8];
            shift_d   = {shift_q[DAT_W-9:0], 8'h00};
            cnt_d     = cnt_q - 3'd1;
          end
        end
      end
      default: ;
    endcase
  end

  assign rx_ready = rx_ready_q;
  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign wb_stb_o = stb_q;
  assign wb_cyc_o = stb_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = shift_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Randomized scoreboard bench for wb_cmd_master: stimulus pushes expected bus
// cycles and response bytes into queues; a negedge monitor plays the wishbone
// slave and pops/compares whenever the DUT strobes the bus or hands off a tx byte.
module tb_wb_cmd_master;

  localparam int TIMEOUT_P = 8;

  typedef struct {
    logic        we;
    logic [6:0]  adr;
    logic [31:0] dat;
    int          len;
  } bus_exp_t;

  typedef struct {
    int          lat;
    logic [31:0] rdata;
  } slave_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid, rx_ready, rx_abort;
  logic [7:0]  rx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  tx_data;
  logic        wb_stb_o, wb_cyc_o, wb_we_o, wb_ack_i;
  logic [6:0]  wb_adr_o;
  logic [31:0] wb_dat_o, wb_dat_i;

  int checks   = 0;
  int failures = 0;

  bus_exp_t   exp_bus[$];
  slave_t     slv_q[$];
  logic [7:0] exp_tx[$];

  logic tx_hold = 1'b0;
  logic abort_at_edge = 1'b0;

  always #5 clk = ~clk;

  wb_cmd_master #(.TIMEOUT(TIMEOUT_P)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .rx_abort (rx_abort),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .wb_stb_o (wb_stb_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_we_o  (wb_we_o),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event seen with nothing expected (t=%0t)", name, $time);
  endtask

  // Random consumer back-pressure, changed just after each rising edge.
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1 tx_ready = tx_hold ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  // Record whether an abort was presented at the edge just taken.
  always @(posedge clk) abort_at_edge = rx_abort;

  // Monitor + wishbone slave: compares bus cycles and tx bytes with the queues.
  bus_exp_t   cur_bus;
  slave_t     cur_slv;
  logic       in_cyc = 1'b0, ack_prev = 1'b0;
  int         hi_cnt = 0;
  logic       txp_valid = 1'b0, txp_fire = 1'b0;
  logic [7:0] txp_data = 8'h00;

  initial begin
    wb_ack_i = 1'b0;
    wb_dat_i = '0;
  end

  always @(negedge clk) begin
    if (!rst) begin
      in_cyc    = 1'b0;
      hi_cnt    = 0;
      ack_prev  = 1'b0;
      wb_ack_i  = 1'b0;
      txp_valid = 1'b0;
      txp_fire  = 1'b0;
    end else begin
      check("cyc_eq_stb", 32'(wb_cyc_o), 32'(wb_stb_o));
      if (ack_prev) check("stb_low_after_ack", 32'(wb_stb_o), 32'd0);
      if (wb_stb_o || tx_valid) check("rx_backpressure", 32'(rx_ready), 32'd0);
      if (wb_stb_o && !in_cyc) begin
        in_cyc = 1'b1;
        hi_cnt = 1;
        if (exp_bus.size() == 0) begin
          flag("unexpected_bus_cycle");
          cur_bus = '{we: wb_we_o, adr: wb_adr_o, dat: wb_dat_o, len: TIMEOUT_P};
        end else begin
          cur_bus = exp_bus.pop_front();
          check("bus_we", 32'(wb_we_o), 32'(cur_bus.we));
          check("bus_adr", 32'(wb_adr_o), 32'(cur_bus.adr));
          if (cur_bus.we) check("bus_wdat", wb_dat_o, cur_bus.dat);
        end
        cur_slv = (slv_q.size() != 0) ? slv_q.pop_front() : '{lat: 0, rdata: 32'h0};
        cur_bus.dat = wb_dat_o;
      end else if (wb_stb_o) begin
        hi_cnt++;
        check("bus_hold", {wb_dat_o[31:8], wb_adr_o, wb_we_o},
              {cur_bus.dat[31:8], cur_bus.adr, cur_bus.we});
      end else if (in_cyc) begin
        in_cyc = 1'b0;
        check("stb_len", 32'(hi_cnt), 32'(cur_bus.len));
      end
      wb_ack_i = wb_stb_o && (hi_cnt == cur_slv.lat);
      wb_dat_i = wb_ack_i ? cur_slv.rdata : $urandom;
      ack_prev = wb_ack_i;

      if (txp_valid && !txp_fire && !abort_at_edge)
        check("tx_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, txp_data});
      if (tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) flag("unexpected_tx_byte");
        else check("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
      end
      txp_valid = tx_valid;
      txp_fire  = tx_valid && tx_ready;
      txp_data  = tx_data;
    end
  end

  // Offer one byte starting at a falling edge; returns at the falling edge after it is taken.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("rx_accept_in_time", 32'(rx_ready), 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!(exp_tx.size() == 0 && !tx_valid && !wb_stb_o && rx_ready) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(n < 3000), 32'd1);
  endtask

  // Reference model: a cycle acked within TIMEOUT cycles is OK; otherwise it times out.
  task automatic run_cmd(input logic we, input logic [6:0] adr, input logic [31:0] dat,
                         input int lat, input logic [31:0] rdata, input string tag);
    logic ok;
    logic [31:0] w;
    ok = (lat >= 1) && (lat <= TIMEOUT_P);
    exp_bus.push_back('{we: we, adr: adr, dat: dat, len: ok ? lat : TIMEOUT_P});
    slv_q.push_back('{lat: lat, rdata: rdata});
    exp_tx.push_back(ok ? 8'hA5 : 8'hE1);
    if (!we && ok) begin
      w = rdata;
      for (int i = 0; i < 4; i++) begin
        exp_tx.push_back(w[31:24]);
        w = w << 8;
      end
    end
    send_byte({we, adr});
    if (we) begin
      w = dat;
      for (int i = 0; i < 4; i++) begin
        send_byte(w[31:24]);
        w = w << 8;
      end
    end
    wait_idle(tag);
  endtask

  task automatic pulse_abort();
    rx_abort = 1'b1;
    @(negedge clk);
    rx_abort = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] r;
    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    rx_abort = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_stb_cyc_we", {29'd0, wb_stb_o, wb_cyc_o, wb_we_o}, 32'd0);
    check("rst_adr", 32'(wb_adr_o), 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    #2 rst = 1'b1;
    @(negedge clk);
    check("rx_ready_after_reset", 32'(rx_ready), 32'd1);

    // Directed write and read.
    run_cmd(1'b1, 7'h13, 32'hDEADBEEF, 2, 32'h0, "write");
    run_cmd(1'b0, 7'h70, 32'h0, 3, 32'h01234567, "read");

    // Timeout (ack never arrives within the limit), then a normal command.
    run_cmd(1'b0, 7'h2A, 32'h0, 100, 32'hCAFEF00D, "timeout");
    run_cmd(1'b0, 7'h2A, 32'h0, TIMEOUT_P, 32'h89ABCDEF, "ack_at_limit");
    run_cmd(1'b1, 7'h01, 32'h55AA33CC, TIMEOUT_P + 1, 32'h0, "write_timeout");

    // Abort in WDATA after two data bytes: nothing on the bus, nothing sent back.
    send_byte(8'h85);
    send_byte(8'h11);
    send_byte(8'h22);
    pulse_abort();
    repeat (4) @(negedge clk);
    check("abort_wdata_no_stb", 32'(wb_stb_o), 32'd0);
    check("abort_wdata_idle", 32'(rx_ready), 32'd1);
    run_cmd(1'b0, 7'h10, 32'h0, 1, 32'h600DCAFE, "after_abort");

    // Abort coinciding with an offered byte in IDLE: the byte is dropped.
    rx_valid = 1'b1;
    rx_data  = 8'h05;
    rx_abort = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_abort = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_prio_no_stb", 32'(wb_stb_o), 32'd0);

    // Abort during the bus cycle: cycle runs to ack, response suppressed.
    exp_bus.push_back('{we: 1'b0, adr: 7'h22, dat: 32'h0, len: 5});
    slv_q.push_back('{lat: 5, rdata: 32'h11223344});
    send_byte(8'h22);
    pulse_abort();
    wait_idle("abort_bus");

    // Abort during the response: pending byte is withdrawn.
    tx_hold = 1'b1;
    repeat (2) @(negedge clk);
    exp_bus.push_back('{we: 1'b0, adr: 7'h44, dat: 32'h0, len: 2});
    slv_q.push_back('{lat: 2, rdata: $urandom});
    send_byte(8'h44);
    n = 0;
    while (!tx_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("resp_abort_status", 32'(tx_data), 32'hA5);
    pulse_abort();
    check("resp_abort_tx_valid", 32'(tx_valid), 32'd0);
    check("resp_abort_idle", 32'(rx_ready), 32'd1);
    tx_hold = 1'b0;
    wait_idle("resp_abort");

    // Back-pressure: a byte held on rx during BUS/RESP is never taken.
    exp_bus.push_back('{we: 1'b0, adr: 7'h3C, dat: 32'h0, len: 6});
    slv_q.push_back('{lat: 6, rdata: 32'hA1B2C3D4});
    exp_tx.push_back(8'hA5);
    exp_tx.push_back(8'hA1);
    exp_tx.push_back(8'hB2);
    exp_tx.push_back(8'hC3);
    exp_tx.push_back(8'hD4);
    send_byte(8'h3C);
    rx_valid = 1'b1;
    rx_data  = 8'hFF;
    n = 0;
    while ((wb_stb_o || tx_valid) && n < 1000) begin
      check("bp_rx_ready", 32'(rx_ready), 32'd0);
      @(negedge clk);
      n++;
    end
    rx_valid = 1'b0;
    wait_idle("backpressure");

    // Reset while stb is high: outputs clear without a clock edge, no response.
    exp_bus.push_back('{we: 1'b1, adr: 7'h55, dat: 32'h12345678, len: 0});
    slv_q.push_back('{lat: 50, rdata: 32'h0});
    send_byte(8'hD5);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h78);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_stb_cyc_we", {29'd0, wb_stb_o, wb_cyc_o, wb_we_o}, 32'd0);
    check("mid_rst_adr", 32'(wb_adr_o), 32'd0);
    check("mid_rst_dat", wb_dat_o, 32'd0);
    check("mid_rst_tx", {23'd0, tx_valid, tx_data}, 32'd0);
    check("mid_rst_rx_ready", 32'(rx_ready), 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_no_stb", 32'(wb_stb_o), 32'd0);
    run_cmd(1'b0, 7'h07, 32'h0, 2, 32'hFEEDFACE, "post_reset");

    // Randomized commands, including latencies past the timeout.
    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      run_cmd(r[7], r[14:8], $urandom, $urandom_range(1, TIMEOUT_P + 3), $urandom, "random");
    end

    repeat (5) @(negedge clk);
    check("exp_tx_drained", 32'(exp_tx.size()), 32'd0);
    check("exp_bus_drained", 32'(exp_bus.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
